// File: rtl/bus_arbiter_nxm_if.sv
`default_nettype none
// ==== bus_arbiter_nxm_if : bus bundle between masters, arbiter and slaves (rev 1.0) ====
interface bus_arbiter_nxm_if #(
  parameter int N_MASTER = 2,
  parameter int N_SLAVE  = 2,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 64
);
  logic [N_MASTER-1:0]        m_req;
  logic [N_MASTER-1:0]        m_wr;
  logic [N_MASTER*ADDR_W-1:0] m_addr;
  logic [N_MASTER*DATA_W-1:0] m_dout;
  logic [N_MASTER-1:0]        m_grant;
  logic [DATA_W-1:0]          m_din;
  logic [N_SLAVE-1:0]         s_sel;
  logic                       s_wr;
  logic [ADDR_W-1:0]          s_addr;
  logic [DATA_W-1:0]          s_din;
  logic [N_SLAVE*DATA_W-1:0]  s_dout;
  logic                       dec_err;

  modport arb (
    input  m_req, m_wr, m_addr, m_dout, s_dout,
    output m_grant, m_din, s_sel, s_wr, s_addr, s_din, dec_err
  );

  modport master (
    output m_req, m_wr, m_addr, m_dout,
    input  m_grant, m_din, dec_err
  );

  modport slave (
    input  s_sel, s_wr, s_addr, s_din,
    output s_dout
  );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_nxm.sv
`default_nettype none
// ==== bus_arbiter_nxm : N-master/M-slave round-robin bus with registered read return (rev 1.0) ====
// Optional BUS_QUANTUM_EN limits how long one owner may keep the bus while others wait.
module bus_arbiter_nxm #(
  parameter int N_MASTER = 2,
  parameter int N_SLAVE  = 2,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 64,
  parameter int SEL_LSB  = 12,
  parameter int QUANTUM  = 16
) (
  input wire              clk,
  input wire              reset_n,
  bus_arbiter_nxm_if.arb  bus
);

  localparam int OWN_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int SEL_W = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [OWN_W-1:0]    ptr_q, ptr_d;
  logic [N_MASTER-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]    rsel_q, rsel_d;
  logic                rsel_vld_q, rsel_vld_d;
  logic                dec_err_q, dec_err_d;

  logic                owner_req;
  logic [N_MASTER-1:0] cand;
  logic [OWN_W-1:0]    win;
  logic                win_vld;
  logic [OWN_W-1:0]    ptr_nxt;
  logic                take;

  logic                active;
  logic [ADDR_W-1:0]   s_addr;
  logic [DATA_W-1:0]   s_din;
  logic                s_wr;
  logic [SEL_W-1:0]    idx;
  logic                idx_ok;
  logic [N_SLAVE-1:0]  s_sel;
  logic [DATA_W-1:0]   m_din;

`ifdef BUS_QUANTUM_EN
  logic [7:0] cnt_q, cnt_d;
  logic       quantum_hit;

  assign quantum_hit = (cnt_q == 8'(QUANTUM));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic [7:0] unused_quantum;
  assign unused_quantum = 8'(QUANTUM);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      rsel_q     <= '0;
      rsel_vld_q <= 1'b0;
      dec_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      rsel_q     <= rsel_d;
      rsel_vld_q <= rsel_vld_d;
      dec_err_q  <= dec_err_d;
    end
  end

  always_comb begin
    owner_req = 1'b0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (owner_q == OWN_W'(i)) owner_req = bus.m_req[i];
    end
  end

  // The current owner is masked out so a forced handoff never re-selects it.
  assign cand = (state_q == ST_OWN) ? (bus.m_req & ~grant_q) : bus.m_req;

  always_comb begin
    int pos;
    win     = '0;
    win_vld = 1'b0;
    pos     = 0;
    for (int k = 0; k < N_MASTER; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= N_MASTER) pos = pos - N_MASTER;
      for (int i = 0; i < N_MASTER; i++) begin
        if (!win_vld && cand[i] && (pos == i)) begin
          win     = OWN_W'(i);
          win_vld = 1'b1;
        end
      end
    end
    if (int'(win) == N_MASTER - 1) ptr_nxt = '0;
    else                           ptr_nxt = win + OWN_W'(1);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    take    = 1'b0;
`ifdef BUS_QUANTUM_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: take = win_vld;
      ST_OWN: begin
        if (!owner_req) begin
          take = win_vld;
          if (!win_vld) state_d = ST_IDLE;
        end
`ifdef BUS_QUANTUM_EN
        else if (quantum_hit && win_vld) begin
          take = 1'b1;
        end else if (!quantum_hit) begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      state_d = ST_OWN;
      owner_d = win;
      ptr_d   = ptr_nxt;
`ifdef BUS_QUANTUM_EN
      cnt_d   = 8'd1;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < N_MASTER; i++) begin
      grant_d[i] = (state_d == ST_OWN) && (owner_d == OWN_W'(i));
    end

    active = (state_q == ST_OWN) && owner_req;
    s_addr = '0;
    s_din  = '0;
    s_wr   = 1'b0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (active && grant_q[i]) begin
        s_addr = bus.m_addr[i*ADDR_W +: ADDR_W];
        s_din  = bus.m_dout[i*DATA_W +: DATA_W];
        s_wr   = bus.m_wr[i];
      end
    end

    idx    = s_addr[SEL_LSB +: SEL_W];
    idx_ok = (int'(idx) < N_SLAVE);
    s_sel  = '0;
    for (int s = 0; s < N_SLAVE; s++) begin
      s_sel[s] = active && idx_ok && (idx == SEL_W'(s));
    end

    rsel_d     = idx;
    rsel_vld_d = active && !s_wr && idx_ok;
    dec_err_d  = active && !idx_ok;

    m_din = '0;
    for (int s = 0; s < N_SLAVE; s++) begin
      if (rsel_vld_q && (rsel_q == SEL_W'(s))) m_din = bus.s_dout[s*DATA_W +: DATA_W];
    end
  end

  assign bus.m_grant = grant_q;
  assign bus.m_din   = m_din;
  assign bus.s_sel   = s_sel;
  assign bus.s_wr    = s_wr;
  assign bus.s_addr  = s_addr;
  assign bus.s_din   = s_din;
  assign bus.dec_err = dec_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_nxm.sv
`default_nettype none
// ==== tb_bus_arbiter_nxm : directed and randomized check of bus_arbiter_nxm against a reference model (rev 1.0) ====
module tb_bus_arbiter_nxm;
  localparam int N_MASTER = 2;
  localparam int N_SLAVE  = 3;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 64;
  localparam int SEL_LSB  = 12;
  localparam int QUANTUM  = 4;
  localparam int SEL_MASK = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_nxm_if #(
    .N_MASTER(N_MASTER), .N_SLAVE(N_SLAVE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) bus ();

  bus_arbiter_nxm #(
    .N_MASTER(N_MASTER), .N_SLAVE(N_SLAVE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .SEL_LSB(SEL_LSB), .QUANTUM(QUANTUM)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  logic [N_MASTER-1:0] req;
  logic [N_MASTER-1:0] wr;
  logic [ADDR_W-1:0]   addr  [N_MASTER];
  logic [DATA_W-1:0]   wdata [N_MASTER];
  logic [DATA_W-1:0]   sdata [N_SLAVE];

  always_comb begin
    bus.m_req  = req;
    bus.m_wr   = wr;
    bus.m_addr = '0;
    bus.m_dout = '0;
    bus.s_dout = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      bus.m_addr[i*ADDR_W +: ADDR_W] = addr[i];
      bus.m_dout[i*DATA_W +: DATA_W] = wdata[i];
    end
    for (int s = 0; s < N_SLAVE; s++) bus.s_dout[s*DATA_W +: DATA_W] = sdata[s];
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner index (-1 = idle), round-robin start, owned-cycle count, read pipe.
  int owner = -1;
  int ptr = 0;
  int cnt = 0;
  bit exp_rvld = 1'b0;
  int exp_ridx = 0;
  bit exp_derr = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N_MASTER-1:0] c);
    for (int k = 0; k < N_MASTER; k++) begin
      if (c[(ptr + k) % N_MASTER]) return (ptr + k) % N_MASTER;
    end
    return -1;
  endfunction

  task automatic take(input int w);
    owner = w;
    ptr   = (w + 1) % N_MASTER;
    cnt   = 1;
  endtask

  task automatic model_reset();
    owner = -1; ptr = 0; cnt = 0;
    exp_rvld = 1'b0; exp_ridx = 0; exp_derr = 1'b0;
  endtask

  task automatic model_edge();
    bit act;
    int idx;
    int w;
    logic [N_MASTER-1:0] others;
    act = (owner >= 0) && req[owner];
    idx = act ? ((int'(addr[owner]) >> SEL_LSB) & SEL_MASK) : 0;
    exp_rvld = act && !wr[owner] && (idx < N_SLAVE);
    exp_ridx = idx;
    exp_derr = act && (idx >= N_SLAVE);
    if (owner < 0) begin
      w = rr_pick(req);
      if (w >= 0) take(w);
    end else if (!req[owner]) begin
      w = rr_pick(req);
      if (w >= 0) take(w);
      else owner = -1;
    end
`ifdef BUS_QUANTUM_EN
    else begin
      others = req;
      others[owner] = 1'b0;
      if (cnt >= QUANTUM && others != '0) take(rr_pick(others));
      else if (cnt < QUANTUM) cnt++;
    end
`else
    others = '0;
`endif
  endtask

  task automatic check_outputs();
    bit act;
    int idx;
    logic [63:0] eg, esel;
    act  = (owner >= 0) && req[owner];
    eg   = (owner < 0) ? 64'd0 : (64'd1 << owner);
    idx  = act ? ((int'(addr[owner]) >> SEL_LSB) & SEL_MASK) : 0;
    esel = (act && idx < N_SLAVE) ? (64'd1 << idx) : 64'd0;
    check("grant",   bus.m_grant, eg);
    check("s_sel",   bus.s_sel,   esel);
    check("s_wr",    bus.s_wr,    act ? 64'(wr[owner]) : 64'd0);
    check("s_addr",  bus.s_addr,  act ? 64'(addr[owner]) : 64'd0);
    check("s_din",   bus.s_din,   act ? wdata[owner] : 64'd0);
    check("m_din",   bus.m_din,   (exp_rvld && exp_ridx < N_SLAVE) ? sdata[exp_ridx] : 64'd0);
    check("dec_err", bus.dec_err, 64'(exp_derr));
  endtask

  task automatic edge_begin();
    @(posedge clk);
    model_edge();
    #1;
    for (int s = 0; s < N_SLAVE; s++) sdata[s] = {$urandom, $urandom};
  endtask

  task automatic edge_end();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    req = '0;
    wr  = '0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_grant", bus.m_grant, 64'd0);
    check("rst_din",   bus.m_din,   64'd0);
    check("rst_derr",  bus.dec_err, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset_n = 1'b1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N_MASTER; i++) begin
      if ($urandom_range(3) == 0) req[i] = ~req[i];
      wr[i]    = 1'($urandom);
      addr[i]  = 16'($urandom);
      wdata[i] = {$urandom, $urandom};
    end
  endtask

  logic [1:0] exp_seq [7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
  logic [1:0] seen_seq [7];
  int hold [N_MASTER];
  int changes;
  logic [N_MASTER-1:0] prev_g;

  initial begin
    req = '0;
    wr  = '0;
    for (int i = 0; i < N_MASTER; i++) begin addr[i] = '0; wdata[i] = '0; end
    for (int s = 0; s < N_SLAVE; s++) sdata[s] = {$urandom, $urandom};

    // Single write from master 0
    do_reset();
    edge_begin();
    req = 2'b01; wr = 2'b01; addr[0] = 16'h0010; wdata[0] = 64'hA5;
    edge_end();
    edge_begin();
    edge_end();
    check("t1_grant", bus.m_grant, 64'h1);
    check("t1_sel",   bus.s_sel,   64'h1);
    check("t1_wr",    bus.s_wr,    64'h1);
    check("t1_din",   bus.s_din,   64'hA5);

    // Both request from reset, each releases after three granted cycles
    do_reset();
    edge_begin();
    req = 2'b11; wr = 2'b00; addr[0] = 16'h0000; addr[1] = 16'h1000;
    for (int i = 0; i < N_MASTER; i++) hold[i] = 0;
    edge_end();
    for (int c = 0; c < 7; c++) begin
      edge_begin();
      seen_seq[c] = bus.m_grant;
      for (int i = 0; i < N_MASTER; i++) begin
        if (bus.m_grant[i]) begin
          hold[i]++;
          if (hold[i] == 3) begin req[i] = 1'b0; hold[i] = 0; end
          else req[i] = 1'b1;
        end else begin
          req[i] = 1'b1;
        end
      end
      edge_end();
    end
    for (int c = 0; c < 7; c++) check($sformatf("t2_seq%0d", c), seen_seq[c], exp_seq[c]);

    // Master 1 read of slave 1
    edge_begin(); req = '0; edge_end();
    edge_begin(); edge_end();
    edge_begin(); req = 2'b10; wr = 2'b00; addr[1] = 16'h1008; edge_end();
    edge_begin(); edge_end();
    check("t3_sel", bus.s_sel, 64'h2);
    edge_begin(); req = '0; edge_end();
    check("t3_din", bus.m_din, sdata[1]);
    edge_begin(); edge_end();
    check("t3_idle_din", bus.m_din, 64'd0);

    // Unmapped slave index
    edge_begin(); req = 2'b01; wr = 2'b00; addr[0] = 16'h3000; edge_end();
    edge_begin(); edge_end();
    check("t4_sel", bus.s_sel, 64'd0);
    edge_begin(); req = '0; edge_end();
    check("t4_derr", bus.dec_err, 64'd1);
    check("t4_din",  bus.m_din,   64'd0);
    edge_begin(); edge_end();
    check("t4_derr_clr", bus.dec_err, 64'd0);

    // Continuous contention
    edge_begin(); req = 2'b11; wr = 2'b00; addr[0] = 16'h0000; addr[1] = 16'h0000; edge_end();
    changes = 0;
    prev_g = '0;
    for (int c = 0; c < 16; c++) begin
      edge_begin();
      edge_end();
      if (c > 0 && bus.m_grant != prev_g) changes++;
      prev_g = bus.m_grant;
    end
`ifdef BUS_QUANTUM_EN
    check("t5_changes", 64'(changes), 64'd3);
`else
    check("t5_changes", 64'(changes), 64'd0);
`endif

    // Reset during a read in flight
    edge_begin(); req = '0; edge_end();
    edge_begin(); req = 2'b10; wr = 2'b00; addr[1] = 16'h1008; edge_end();
    edge_begin(); edge_end();
    edge_begin(); edge_end();
    check("t6_din_live", bus.m_din, sdata[1]);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_grant", bus.m_grant, 64'd0);
    check("t6_din",   bus.m_din,   64'd0);
    check("t6_derr",  bus.dec_err, 64'd0);
    model_reset();
    req = 2'b11;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check_outputs();
    edge_begin(); edge_end();
    check("t6_restart", bus.m_grant, 64'h1);

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      edge_begin();
      rand_inputs();
      edge_end();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/bus_arbiter_nxm.md
# bus_arbiter_nxm

Parametrised multi-master, multi-slave system bus with round-robin arbitration, field-based address decode and a one-cycle registered read-data return path. It replaces the single-master bus between the host-side master ports and the slaves (RAM, FactoCore and later cores). The `_nxm` suffix keeps the name distinct from the existing `BUS` module. Slave select, write and address/data routing follow the granted master. Read data returns the cycle after the access, matching synchronous-read slaves.

## Interface
- N_MASTER, 2, number of master ports (1..8)
- N_SLAVE, 2, number of slave ports (1..8)
- ADDR_W, 16, address width
- DATA_W, 64, data width
- SEL_LSB, 12, LSB of slave-index field in address; field width SEL_W = clog2(N_SLAVE) (min 1)
- QUANTUM, 16, max consecutive owned cycles when BUS_QUANTUM_EN defined (2..255)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- m_req  in  N_MASTER  per-master bus request
- m_wr  in  N_MASTER  per-master write strobe (1=write, 0=read)
- m_addr  in  N_MASTER*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
- m_dout  in  N_MASTER*DATA_W  packed write data
- m_grant  out  N_MASTER  one-hot grant, registered
- m_din  out  DATA_W  read data, broadcast to all masters
- s_sel  out  N_SLAVE  one-hot slave select
- s_wr  out  1  write strobe to slaves
- s_addr  out  ADDR_W  address to slaves
- s_din  out  DATA_W  write data to slaves
- s_dout  in  N_SLAVE*DATA_W  packed slave read data
- dec_err  out  1  registered pulse, one cycle, on access to unmapped index

## Operation
- States:
  - IDLE: no owner.
  - OWN: exactly one m_grant bit high.
- Reset: m_grant=0, state IDLE, RR pointer = 0 (master 0 highest priority), rsel_vld=0, dec_err=0.
- IDLE→OWN: any m_req high at edge. Winner is first requester scanning from pointer upward with wrap. Pointer ← winner+1 mod N_MASTER.
- OWN, owner m_req high: hold grant.
- OWN, owner m_req low:
  - If other requests exist, grant passes to the RR winner on the same edge (no idle cycle).
  - Otherwise → IDLE, m_grant=0.
- Slave-side outputs are combinational from the owner while in OWN and m_req[owner]=1:
  - s_addr = m_addr[owner], s_din = m_dout[owner], s_wr = m_wr[owner].
  - idx = s_addr[SEL_LSB +: SEL_W]; s_sel[idx]=1 if idx < N_SLAVE.
- Otherwise s_sel=0, s_wr=0, s_addr=0, s_din=0.
- Decode error (idx ≥ N_SLAVE while an access is active): s_sel=0, no write occurs, dec_err=1 next cycle, read returns 0.
- Read return: each edge, rsel_q ← idx and rsel_vld ← (active && !s_wr && idx<N_SLAVE). m_din = rsel_vld ? s_dout[rsel_q] : 0.

## Timing
- Grant latency: 1 cycle from m_req rising (sampled) to m_grant.
- Master may drive its access in the cycle m_grant is seen high. The access reaches slaves combinationally in that cycle.
- Read data valid on m_din exactly 1 cycle after the read cycle. Back-to-back reads give one result per cycle.
- Handoff: last owner cycle and first new-owner cycle are adjacent. The read data of the last owner's final read appears in the new owner's first cycle; masters qualify by their own read tracking.
- Simultaneous requests from all masters: grant rotates 0,1,…,N-1,0 as owners release.
- reset_n low mid-transfer: all outputs go to reset values immediately (asynchronous). An in-flight read is discarded.

## Configuration
- BUS_QUANTUM_EN defined: an owner counter counts cycles in OWN. When it reaches QUANTUM and another master requests, the grant is forced to the RR winner on that edge and the counter restarts. If no other requester exists, the owner keeps the bus and the counter saturates.
- Not defined: no counter; the owner holds indefinitely while m_req stays high. QUANTUM is ignored.

## Test plan
- Reset, then m_req=2'b01, m_wr=1, addr 0x0010, data 0xA5 → m_grant=01 next cycle; s_sel=01, s_wr=1, s_din=0xA5 that cycle.
- m_req=2'b11 from reset, each holds 3 cycles → grant 01 (3 cycles), then 10 with no gap, then 01.
- Master 1 reads 0x1008 (N_SLAVE=2, SEL_LSB=12) → s_sel=10; m_din = slave1 data on the following cycle; 0 when idle.
- N_SLAVE=3, read addr 0x3000 → s_sel=000, dec_err=1 one cycle later, m_din=0.
- BUS_QUANTUM_EN, QUANTUM=4, both requesting continuously → grant alternates every 4 cycles. Without the macro → master 0 keeps the grant.
- reset_n pulsed low mid-read → m_grant=0, m_din=0, dec_err=0 immediately. After release, arbitration restarts at master 0.
